// File: rtl/lab3_vector_sweep.sv
// lab3_vector_sweep
//   Drives all 16 input vectors {w,x,y,z} = 0..15 into an external 4-input
//   logic stage, lets each vector settle for SETTLE cycles, samples the
//   returned f for one cycle, and compares against the golden table EXPECT.
//
// Parameters
//   SETTLE  cycles each vector is held before sampling (1..15)
//   EXPECT  golden truth table, bit i = expected f for vector i
//
// Ports
//   CL2947MP_clk         clock, rising edge
//   CL2947MP_rst_n       synchronous active-low reset
//   CL2947MP_start       sweep request (sampled in IDLE/DONE)
//   CL2947MP_abort       ends an active sweep, priority over start
//   CL2947MP_f           function value returned by the downstream stage
//   CL2947MP_w/x/y/z     registered stimulus, w = idx[3], z = idx[0]
//   CL2947MP_truth       captured f per vector index
//   CL2947MP_busy        high while settling or sampling
//   CL2947MP_done        high once all 16 vectors are captured
//   CL2947MP_mis_cnt     number of mismatching vectors (0..16)
//   CL2947MP_first_fail  lowest failing index, valid with fail_vld
//   CL2947MP_fail_vld    at least one mismatch in the current sweep
//   CL2947MP_pass        done with zero mismatches
module lab3_vector_sweep #(
  parameter int unsigned SETTLE = 1,
  parameter logic [15:0] EXPECT = 16'hDF71
) (
  input  logic        CL2947MP_clk,
  input  logic        CL2947MP_rst_n,
  input  logic        CL2947MP_start,
  input  logic        CL2947MP_abort,
  input  logic        CL2947MP_f,
  output logic        CL2947MP_w,
  output logic        CL2947MP_x,
  output logic        CL2947MP_y,
  output logic        CL2947MP_z,
  output logic [15:0] CL2947MP_truth,
  output logic        CL2947MP_busy,
  output logic        CL2947MP_done,
  output logic [4:0]  CL2947MP_mis_cnt,
  output logic [3:0]  CL2947MP_first_fail,
  output logic        CL2947MP_fail_vld,
  output logic        CL2947MP_pass
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] idx;
  logic [3:0] cnt;
  logic       mismatch;

  // The stimulus pins are the index register itself, so they always show the
  // vector under test (and 4'b1111 once the sweep has finished).
  assign {CL2947MP_w, CL2947MP_x, CL2947MP_y, CL2947MP_z} = idx;

  assign mismatch = (CL2947MP_f != EXPECT[idx]);

  always_ff @(posedge CL2947MP_clk) begin
    if (!CL2947MP_rst_n) begin
      state               <= ST_IDLE;
      idx                 <= '0;
      cnt                 <= '0;
      CL2947MP_truth      <= '0;
      CL2947MP_mis_cnt    <= '0;
      CL2947MP_first_fail <= '0;
      CL2947MP_fail_vld   <= 1'b0;
      CL2947MP_busy       <= 1'b0;
      CL2947MP_done       <= 1'b0;
      CL2947MP_pass       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (CL2947MP_abort) begin
            state         <= ST_IDLE;
            CL2947MP_done <= 1'b0;
            CL2947MP_pass <= 1'b0;
          end else if (CL2947MP_start) begin
            state               <= ST_SETTLE;
            idx                 <= '0;
            cnt                 <= RELOAD;
            CL2947MP_truth      <= '0;
            CL2947MP_mis_cnt    <= '0;
            CL2947MP_first_fail <= '0;
            CL2947MP_fail_vld   <= 1'b0;
            CL2947MP_busy       <= 1'b1;
            CL2947MP_done       <= 1'b0;
            CL2947MP_pass       <= 1'b0;
          end
        end

        ST_SETTLE: begin
          if (CL2947MP_abort) begin
            state         <= ST_IDLE;
            CL2947MP_busy <= 1'b0;
          end else if (cnt == '0) begin
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        ST_SAMPLE: begin
          // An abort in this cycle suppresses the capture entirely.
          if (CL2947MP_abort) begin
            state         <= ST_IDLE;
            CL2947MP_busy <= 1'b0;
          end else begin
            CL2947MP_truth[idx] <= CL2947MP_f;
            if (mismatch) begin
              if (CL2947MP_mis_cnt != 5'd16)
                CL2947MP_mis_cnt <= CL2947MP_mis_cnt + 5'd1;
              if (!CL2947MP_fail_vld) begin
                CL2947MP_first_fail <= idx;
                CL2947MP_fail_vld   <= 1'b1;
              end
            end
            if (idx == 4'd15) begin
              state         <= ST_DONE;
              CL2947MP_busy <= 1'b0;
              CL2947MP_done <= 1'b1;
              // pass is registered, so fold in the last vector's result here.
              CL2947MP_pass <= (CL2947MP_mis_cnt == '0) && !mismatch;
            end else begin
              state <= ST_SETTLE;
              idx   <= idx + 4'd1;
              cnt   <= RELOAD;
            end
          end
        end

        default: begin
          state         <= ST_IDLE;
          CL2947MP_busy <= 1'b0;
          CL2947MP_done <= 1'b0;
          CL2947MP_pass <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lab3_vector_sweep.md
LAB3_VECTOR_SWEEP -- requirements
Module: lab3_vector_sweep

Interface
REQ-001 Parameter SETTLE, default 1, number of cycles each vector is driven before sampling; legal range 1..15.
REQ-002 Parameter EXPECT, default 16'hDF71, golden truth table; bit i is the expected f for vector i = {w,x,y,z}.
REQ-003 CL2947MP_clk  input  1  single clock; all state updates on rising edge.
REQ-004 CL2947MP_rst_n  input  1  reset; synchronous, active-low.
REQ-005 CL2947MP_start  input  1  level; sweep request, sampled in IDLE and DONE only.
REQ-006 CL2947MP_abort  input  1  level; ends an active sweep.
REQ-007 CL2947MP_f  input  1  function output returned from the downstream 4-input logic stage.
REQ-008 CL2947MP_w, CL2947MP_x, CL2947MP_y, CL2947MP_z  output  1 each  registered stimulus to the downstream stage; w = idx[3], z = idx[0].
REQ-009 CL2947MP_truth  output  16  captured f per vector index.
REQ-010 CL2947MP_busy  output  1  high in SETTLE and SAMPLE.
REQ-011 CL2947MP_done  output  1  high in DONE.
REQ-012 CL2947MP_mis_cnt  output  5  count of vectors where captured f != EXPECT bit, range 0..16.
REQ-013 CL2947MP_first_fail  output  4  index of the lowest failing vector; valid only when fail_vld=1.
REQ-014 CL2947MP_fail_vld  output  1  at least one mismatch recorded in the current sweep.
REQ-015 CL2947MP_pass  output  1  done=1 and mis_cnt=0.

Function
REQ-016 FSM states are IDLE, SETTLE, SAMPLE and DONE.
REQ-017 IDLE or DONE with start=1 and abort=0 -> SETTLE; same edge clears idx to 0, truth to 0, mis_cnt to 0, fail_vld to 0, first_fail to 0, and loads settle counter to SETTLE-1.
REQ-018 SETTLE: w/x/y/z = idx; counter decrements each cycle; at counter 0 -> SAMPLE; SETTLE therefore lasts exactly SETTLE cycles.
REQ-019 SAMPLE lasts one cycle: truth[idx] <= f; on mismatch with EXPECT[idx], mis_cnt increments, and if fail_vld=0 then first_fail <= idx and fail_vld <= 1.
REQ-020 SAMPLE with idx<15 -> SETTLE, idx+1, counter reload; SAMPLE with idx=15 -> DONE, idx holds at 15.
REQ-021 Sweep latency is 16*(SETTLE+1) cycles from the start-accept edge to the DONE-entry edge; this is 32 cycles at SETTLE=1.
REQ-022 start while busy is ignored; no restart occurs and no partial results are cleared.
REQ-023 abort=1 in SETTLE or SAMPLE -> IDLE on the next edge, and the SAMPLE capture of that cycle is suppressed.
REQ-024 After abort, truth, mis_cnt, first_fail and fail_vld keep partial results, idx holds, and done stays 0.
REQ-025 abort has priority over start; abort=1 in IDLE or DONE keeps or moves the FSM to IDLE.
REQ-026 DONE holds all results and w/x/y/z = 4'b1111 until start or abort.
REQ-027 mis_cnt never exceeds 16 and never wraps.

Reset
REQ-028 When rst_n=0 at an edge: state=IDLE, idx=0, w/x/y/z=0, truth=16'h0000, mis_cnt=0, first_fail=0, fail_vld=0, busy=0, done=0, pass=0, counter=0.
REQ-029 Reset overrides start and abort, and aborts any sweep mid-operation with no partial results retained.

Verification
REQ-030 Correct stage model f = wx'+wy+xz'+y'z'+w'xy', SETTLE=1, start pulse -> done rises 32 cycles later, truth=16'hDF71, mis_cnt=0, fail_vld=0, pass=1.
REQ-031 Inverted-output stage (NOR of the same terms) -> truth=16'h208E, mis_cnt=16, first_fail=0, fail_vld=1, pass=0.
REQ-032 f stuck at 0 -> truth=16'h0000, mis_cnt=11, first_fail=0; f stuck at 1 -> truth=16'hFFFF, mis_cnt=5, first_fail=1.
REQ-033 SETTLE=3 with the correct model -> each vector held 3 cycles then sampled, done after 64 cycles, and w/x/y/z step through 0..15 in order.
REQ-034 abort during vector 5 SAMPLE -> IDLE next cycle, truth[5]=0, truth[4:0]=5'h11, done=0; rst_n=0 mid-sweep -> all REQ-028 values one edge later.
REQ-035 start held high through a sweep -> ignored while busy; a new sweep starts the cycle after DONE entry, and results are cleared on that edge.
